// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : RV32 execute stage. It takes the fetch/execute pipeline
//               register outputs and produces the registered EX/MEM state.
//               The stage forwards operands from MEM and WB, and contains the
//               ALU and branch/jump resolution with a registered redirect. It
//               also has an iterative shift-add multiplier (MUL, MULHU) that
//               stalls upstream while it runs.
// Ports       : clk, rst (sync, active-high), flush
//               in_*          decoded instruction fields, operands, controls
//               mem_fwd_*     pending MEM-stage register write
//               wb_fwd_*      pending WB-stage register write
//               stall         combinational; upstream holds in_* while high
//               out_*         registered EX/MEM state and redirect request
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] in_read_data1,
    input  logic [XLEN-1:0] in_read_data2,
    input  logic [4:0]      in_read_reg1,
    input  logic [4:0]      in_read_reg2,
    input  logic [4:0]      in_write_reg,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_PC,
    input  logic [XLEN-1:0] in_nextPC,
    input  logic            in_reg_write,
    input  logic            in_mem_reg,
    input  logic            in_mem_write,
    input  logic            in_alu_src,
    input  logic            in_branch,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic [2:0]      in_itype,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_reg,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_reg,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            stall,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_write_reg,
    output logic            out_reg_write,
    output logic            out_mem_reg,
    output logic            out_mem_write,
    output logic [2:0]      out_funct3,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target
);

    localparam int CW = $clog2(MUL_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] IT_R     = 3'd0;
    localparam logic [2:0] IT_LOAD  = 3'd2;
    localparam logic [2:0] IT_STORE = 3'd3;
    localparam logic [2:0] IT_LUI   = 3'd5;
    localparam logic [2:0] IT_AUIPC = 3'd6;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_acc;      // high half: partial sum, low half: multiplier
    logic [XLEN-1:0]   r_mcand;

    logic [XLEN-1:0]   w_rs1;
    logic [XLEN-1:0]   w_rs2;
    logic [XLEN-1:0]   w_op_b;
    logic [4:0]        w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic [XLEN-1:0]   w_result;
    logic              w_cond;
    logic              w_taken;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_target;
    logic              w_is_mul;
    logic              w_mul_ok;
    logic              w_bubble;
    logic              w_out_en;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_next;

    // ------------------------------------------------------------------
    // Operand forwarding: MEM is newer than WB, and x0 never forwards.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs1 = in_read_data1;
        if (in_read_reg1 != 5'd0 && mem_fwd_en && mem_fwd_reg == in_read_reg1)
            w_rs1 = mem_fwd_data;
        else if (in_read_reg1 != 5'd0 && wb_fwd_en && wb_fwd_reg == in_read_reg1)
            w_rs1 = wb_fwd_data;
    end

    always_comb begin
        w_rs2 = in_read_data2;
        if (in_read_reg2 != 5'd0 && mem_fwd_en && mem_fwd_reg == in_read_reg2)
            w_rs2 = mem_fwd_data;
        else if (in_read_reg2 != 5'd0 && wb_fwd_en && wb_fwd_reg == in_read_reg2)
            w_rs2 = wb_fwd_data;
    end

    assign w_op_b  = in_alu_src ? in_imm : w_rs2;
    assign w_shamt = w_op_b[4:0];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (in_funct3)
            3'b000: w_alu = (in_itype == IT_R && in_funct7[5]) ? (w_rs1 - w_op_b)
                                                               : (w_rs1 + w_op_b);
            3'b001: w_alu = w_rs1 << w_shamt;
            3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_rs1) < $signed(w_op_b))};
            3'b011: w_alu = {{(XLEN-1){1'b0}}, (w_rs1 < w_op_b)};
            3'b100: w_alu = w_rs1 ^ w_op_b;
            3'b101: w_alu = in_funct7[5] ? XLEN'($signed(w_rs1) >>> w_shamt)
                                         : (w_rs1 >> w_shamt);
            3'b110: w_alu = w_rs1 | w_op_b;
            default: w_alu = w_rs1 & w_op_b;
        endcase
        // Address generation and special result sources override funct3.
        if (in_itype == IT_LOAD || in_itype == IT_STORE)
            w_alu = w_rs1 + w_op_b;
        if (in_itype == IT_LUI)
            w_alu = in_imm;
        if (in_itype == IT_AUIPC)
            w_alu = in_PC + in_imm;
        if (in_jal || in_jalr)
            w_alu = in_nextPC;
    end

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------
    always_comb begin
        w_cond = 1'b0;
        case (in_funct3)
            3'b000:  w_cond = (w_rs1 == w_rs2);
            3'b001:  w_cond = (w_rs1 != w_rs2);
            3'b100:  w_cond = ($signed(w_rs1) < $signed(w_rs2));
            3'b101:  w_cond = ($signed(w_rs1) >= $signed(w_rs2));
            3'b110:  w_cond = (w_rs1 < w_rs2);
            3'b111:  w_cond = (w_rs1 >= w_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken    = (in_branch && w_cond) || in_jal || in_jalr;
    assign w_jalr_sum = w_rs1 + in_imm;
    assign w_target   = in_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (in_PC + in_imm);

    // ------------------------------------------------------------------
    // Multiplier control
    // ------------------------------------------------------------------
    assign w_is_mul = (in_itype == IT_R) && (in_funct7 == 7'b0000001);
    assign w_mul_ok = w_is_mul && (in_funct3 == 3'b000 || in_funct3 == 3'b011);

    // One shift-add step; the carry out of the high-half add shifts in at the top.
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand};
    assign w_acc_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]}
                                 : {1'b0, r_acc[2*XLEN-1:1]};

    // Reset gates stall so upstream is never held while the stage is being reset.
    assign stall = !rst && ((r_state == S_IDLE && w_mul_ok) || r_state == S_BUSY);

    // In DONE the multiply is still on the inputs, so funct3 selects the half.
    always_comb begin
        if (r_state == S_DONE)
            w_result = (in_funct3 == 3'b011) ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
        else if (w_is_mul)
            w_result = '0;
        else
            w_result = w_alu;
    end

    // Outputs hold their bubble while BUSY unless a flush arrives.
    assign w_out_en = flush || (r_state != S_BUSY);
    assign w_bubble = flush || (r_state == S_IDLE && w_mul_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_ok) begin
                        r_acc   <= {{XLEN{1'b0}}, w_rs1};
                        r_mcand <= w_rs2;
                        r_count <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(MUL_CYCLES - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_alu_result <= '0;
            out_store_data <= '0;
            out_write_reg  <= '0;
            out_reg_write  <= 1'b0;
            out_mem_reg    <= 1'b0;
            out_mem_write  <= 1'b0;
            out_funct3     <= '0;
            out_redirect   <= 1'b0;
            out_target     <= '0;
        end else if (w_out_en) begin
            out_alu_result <= w_bubble ? '0 : w_result;
            out_store_data <= w_bubble ? '0 : w_rs2;
            out_write_reg  <= w_bubble ? '0 : in_write_reg;
            out_reg_write  <= !w_bubble && in_reg_write;
            out_mem_reg    <= !w_bubble && in_mem_reg;
            out_mem_write  <= !w_bubble && in_mem_write;
            out_funct3     <= w_bubble ? '0 : in_funct3;
            out_redirect   <= !w_bubble && w_taken;
            out_target     <= w_bubble ? '0 : w_target;
        end
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32 execute stage sitting directly downstream of the fetch/execute pipeline register; consumes its outputs and produces the registered EX/MEM state for the memory stage.
- Contains operand forwarding, ALU, branch/jump resolution with registered redirect, and an iterative 32-cycle shift-add multiplier (MUL, MULHU) that stalls upstream.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, multiplier iterations; must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  convert the current instruction to a bubble and abort any multiply.
- in_read_data1, in_read_data2  in  32  register-file operands.
- in_read_reg1, in_read_reg2, in_write_reg  in  5  rs1, rs2 and rd indices.
- in_imm, in_PC, in_nextPC  in  32  immediate, instruction PC, PC+4.
- in_reg_write, in_mem_reg, in_mem_write, in_alu_src, in_branch, in_jal, in_jalr  in  1  control signals.
- in_itype  in  3  0=R, 1=I-ALU, 2=load, 3=store, 4=branch, 5=LUI, 6=AUIPC, 7=jump.
- in_funct3  in  3  function field.
- in_funct7  in  7  function field.
- mem_fwd_en, wb_fwd_en  in  1  a MEM-stage / WB-stage write to a register is pending.
- mem_fwd_reg, wb_fwd_reg  in  5  destination index of that write.
- mem_fwd_data, wb_fwd_data  in  32  data of that write.
- stall  out  1  combinational; upstream holds all in_* stable while high.
- out_alu_result, out_store_data  out  32  registered EX/MEM result and store data.
- out_write_reg  out  5  registered rd.
- out_reg_write, out_mem_reg, out_mem_write  out  1  registered controls.
- out_funct3  out  3  registered access size for the memory stage.
- out_redirect  out  1  registered redirect request to fetch.
- out_target  out  32  registered redirect target PC.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE, iteration counter to 0.
  - stall is 0 in the cycle after rst is sampled.
- Forwarding (per operand, rsN index non-zero):
  - mem_fwd_en && mem_fwd_reg==rsN selects mem_fwd_data.
  - Otherwise wb_fwd_en && wb_fwd_reg==rsN selects wb_fwd_data.
  - Otherwise in_read_dataN.
  - MEM has priority over WB. Index 0 never forwards.
  - out_store_data is the forwarded rs2.
- ALU operand B is imm when in_alu_src=1, else forwarded rs2.
- Operations, decoded by funct3/funct7[5]:
  - ADD, SUB (R only), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount is B[4:0].
  - Loads and stores use ADD.
  - LUI yields imm; AUIPC yields PC+imm.
  - jal/jalr yield in_nextPC.
- Branch compare on forwarded operands: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Other funct3 values mean not taken.
- Redirect:
  - taken = (in_branch && cond) || in_jal || in_jalr.
  - out_redirect <= taken; it is 1 for exactly one cycle per taken instruction.
  - Target is PC+imm for branch/jal, and (rs1+imm)&~1 for jalr. All arithmetic is mod 2^32.
- Multiply ops are itype=0 with funct7=0000001:
  - funct3 000 gives the low 32 bits of the unsigned product (equals MUL).
  - funct3 011 gives the high 32 bits of the unsigned product (MULHU).
  - Any other funct3 yields a result of 0, with normal single-cycle latency and no stall.
- FSM IDLE:
  - Non-multiply: outputs load the result at the edge (1-cycle latency), stall=0.
  - Supported multiply: stall=1. Latch the forwarded operands into a 64-bit accumulator and multiplicand. Outputs load a bubble. Go to BUSY with count=0.
- FSM BUSY:
  - stall=1, outputs hold the bubble.
  - Each cycle: if multiplier LSB=1, add the multiplicand to the accumulator high half; then shift right 1; count++.
  - After count=MUL_CYCLES-1, go to DONE.
- FSM DONE:
  - stall=0. Inputs still hold the multiply.
  - Outputs load the selected product half with the instruction's controls. Go to IDLE; never restarts.
- Multiply timing: stall is high for 33 cycles; the result appears at outputs 34 edges after issue.
- Bubble means out_reg_write, out_mem_reg, out_mem_write and out_redirect are 0. Data outputs are don't-care, but the implementation drives them to 0.
- Writes to rd=0 pass through unchanged; the register file ignores them.
- flush:
  - Outputs load a bubble at the edge.
  - The FSM returns to IDLE from any state and discards the accumulator.
  - stall drops in the next cycle.
  - flush overrides a taken redirect in the same cycle.
- rst overrides flush and all other inputs in any state, including mid-multiply.

Test Plan:
- Reset: hold rst for 2 cycles during a multiply -> all outputs 0, stall=0 in the following cycle, and the next ADD completes normally.
- Forwarding: R-type ADD with rs1=5, rs2=6, rd=7, read data 1 and 2, mem_fwd(reg 5, 100), wb_fwd(reg 5, 200; reg 6, 300) -> out_alu_result=400. With rs1=0 and mem_fwd_reg=0 -> operand 0 is used.
- Branches:
  - BLT with rs1=0xFFFFFFFF, rs2=1, PC=0x40, imm=-8 -> out_redirect=1 for one cycle, out_target=0x38.
  - BLTU with the same operands -> out_redirect=0.
- Jumps:
  - jalr with rs1=0x1001, imm=4, nextPC=0x84 -> out_target=0x1004, out_alu_result=0x84, out_reg_write=1.
  - jal with PC=0x100, imm=0x20 -> out_target=0x120.
- Multiply:
  - MUL with 0xFFFFFFFF*2 -> stall high for exactly 33 cycles, bubbles on outputs meanwhile, then out_alu_result=0xFFFFFFFE.
  - MULHU with the same operands -> 0x00000001.
  - Back-to-back MUL then ADD -> the ADD result appears on the edge after the MUL result.
- Flush: assert flush at BUSY count=10 -> bubble on outputs, stall=0 in the next cycle, no result is ever written. Flush on a taken BEQ -> out_redirect=0.
